// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with big-endian load extraction and register file writeback.
// Optional retire counter enabled by defining WB_RETIRE_COUNT_EN.
module mem_wb_writeback #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic                 in_regWrite,
    input  logic                 in_memToReg,
    input  logic                 in_link,
    input  logic [2:0]           in_loadType,
    input  logic [31:0]          in_aluResult,
    input  logic [31:0]          in_memData,
    input  logic [31:0]          in_pcPlus4,
    input  logic [4:0]           in_writeAddress,
    output logic                 regWrite,
    output logic [4:0]           writeAddress,
    output logic [31:0]          writeData,
    output logic                 wbValid,
    output logic [CNT_WIDTH-1:0] retiredCount
);

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic        reg_valid;
    logic        reg_regWrite;
    logic        reg_memToReg;
    logic        reg_link;
    logic [2:0]  reg_loadType;
    logic [31:0] reg_aluResult;
    logic [31:0] reg_memData;
    logic [31:0] reg_pcPlus4;
    logic [4:0]  reg_writeAddress;

    // Flush beats stall so a bubble can be injected even while the stage is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            reg_valid        <= 1'b0;
            reg_regWrite     <= 1'b0;
            reg_memToReg     <= 1'b0;
            reg_link         <= 1'b0;
            reg_loadType     <= 3'b000;
            reg_aluResult    <= 32'h0;
            reg_memData      <= 32'h0;
            reg_pcPlus4      <= 32'h0;
            reg_writeAddress <= 5'h0;
        end else if (!stall) begin
            reg_valid        <= in_valid;
            reg_regWrite     <= in_regWrite;
            reg_memToReg     <= in_memToReg;
            reg_link         <= in_link;
            reg_loadType     <= in_loadType;
            reg_aluResult    <= in_aluResult;
            reg_memData      <= in_memData;
            reg_pcPlus4      <= in_pcPlus4;
            reg_writeAddress <= in_writeAddress;
        end
    end

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // Big-endian: offset 0 addresses the most significant byte.
    always_comb begin
        load_byte = 8'h0;
        case (reg_aluResult[1:0])
            2'd0: load_byte = reg_memData[31:24];
            2'd1: load_byte = reg_memData[23:16];
            2'd2: load_byte = reg_memData[15:8];
            2'd3: load_byte = reg_memData[7:0];
            default: load_byte = 8'h0;
        endcase
        load_half = reg_aluResult[1] ? reg_memData[15:0] : reg_memData[31:16];

        case (reg_loadType)
            LT_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            LT_LBU:  load_data = {24'h0, load_byte};
            LT_LH:   load_data = {{16{load_half[15]}}, load_half};
            LT_LHU:  load_data = {16'h0, load_half};
            default: load_data = reg_memData;
        endcase
    end

    always_comb begin
        writeData = 32'h0;
        if (reg_valid) begin
            if (reg_link)
                writeData = reg_pcPlus4;
            else if (reg_memToReg)
                writeData = load_data;
            else
                writeData = reg_aluResult;
        end
    end

    assign wbValid      = reg_valid;
    assign regWrite     = reg_valid & reg_regWrite & (reg_writeAddress != 5'd0);
    assign writeAddress = reg_valid ? reg_writeAddress : 5'd0;

`ifdef WB_RETIRE_COUNT_EN
    logic [CNT_WIDTH-1:0] retire_cnt;

    // A held instruction retires only once, on the cycle the stall releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retire_cnt <= '0;
        else if (reg_valid && !stall)
            retire_cnt <= retire_cnt + 1'b1;
    end

    assign retiredCount = retire_cnt;
`else
    assign retiredCount = '0;
`endif

endmodule
